// File: rtl/wb_ram_slave_pkg.sv
// wb_ram_slave_pkg: shared Wishbone widths and responder FSM state encoding.
package wb_ram_slave_pkg;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;
    localparam int WS_W    = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/wb_ram_slave_ram_sp_be.sv
// ram_sp_be: single-port 32-bit RAM with byte enables and synchronous read.
module ram_sp_be
  import wb_ram_slave_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [WB_SELW-1:0]    be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WB_DW-1:0]      wdata_i,
  output logic [WB_DW-1:0]      rdata_o
);
  logic [WB_DW-1:0] mem [0:(2**ADDR_WIDTH)-1];
  logic [WB_DW-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (en_i && !we_i) rdata_q <= mem[addr_i];
    if (en_i && we_i)
      for (int i = 0; i < WB_SELW; i++)
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 classic responder for a byte-writable RAM window.
// Requests are latched on acceptance; the RAM is accessed on the edge entering RESP.
module wb_ram_slave
    import wb_ram_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [WB_DW-1:0]   wb_dat_i,
    output logic [WB_DW-1:0]   wb_dat_o,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [WB_SELW-1:0] wb_sel_i,
    output logic               wb_ack_o,
    output logic               wb_err_o
);
    localparam logic [WS_W-1:0] WS = WS_W'(WAIT_STATES);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [WB_DW-1:0]      dat_q;
    logic [WB_SELW-1:0]    sel_q;
    logic                  we_q, hit_q, ack_q, err_q, zero_q;
    logic [WS_W-1:0]       cnt_q;

    logic                  req_d, hit_d, idle_d, go_d, cur_hit, cur_we;
    logic [ADDR_WIDTH-1:0] cur_adr;
    logic [WB_DW-1:0]      cur_dat, rdata;
    logic [WB_SELW-1:0]    cur_sel;
    logic                  unused_lanes;

    assign unused_lanes = ^wb_adr_i[1:0];
    assign req_d   = wb_cyc_i & wb_stb_i;
    assign hit_d   = wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
    assign idle_d  = state_q == S_IDLE;
    // With no wait states the accepting edge is also the edge entering RESP, so use live inputs.
    assign go_d    = idle_d ? (req_d && WAIT_STATES == 0)
                            : (state_q == S_WAIT && cnt_q == '0 && wb_cyc_i);
    assign cur_hit = idle_d ? hit_d : hit_q;
    assign cur_we  = idle_d ? wb_we_i : we_q;
    assign cur_adr = idle_d ? wb_adr_i[ADDR_WIDTH+1:2] : adr_q;
    assign cur_dat = idle_d ? wb_dat_i : dat_q;
    assign cur_sel = idle_d ? wb_sel_i : sel_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            ack_q <= go_d & cur_hit;
            err_q <= go_d & ~cur_hit;
            if (go_d) zero_q <= ~cur_hit | (zero_q & cur_we);
            case (state_q)
                S_IDLE: if (req_d) begin
                    adr_q   <= wb_adr_i[ADDR_WIDTH+1:2];
                    dat_q   <= wb_dat_i;
                    sel_q   <= wb_sel_i;
                    we_q    <= wb_we_i;
                    hit_q   <= hit_d;
                    cnt_q   <= WS == '0 ? '0 : WS - 1'b1;
                    state_q <= WAIT_STATES == 0 ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    state_q <= !wb_cyc_i ? S_IDLE : cnt_q == '0 ? S_RESP : S_WAIT;
                    cnt_q   <= cnt_q == '0 ? '0 : cnt_q - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    ram_sp_be #(.ADDR_WIDTH(ADDR_WIDTH), .INIT_FILE(INIT_FILE)) u_ram (
        .clk_i  (wb_clk_i),
        .en_i   (go_d & cur_hit),
        .we_i   (cur_we),
        .be_i   (cur_sel),
        .addr_i (cur_adr),
        .wdata_i(cur_dat),
        .rdata_o(rdata)
    );

    assign wb_dat_o = zero_q ? '0 : rdata;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
endmodule
